// File: rtl/rs2_lv_sched.sv
// rs2_lv_sched -- RS2 read-port scheduler for the stack cache.
//
// Forms the RS2 read address as vars_ptr + offset, sequences 64-bit reads
// as two back-to-back words, replays a read after a stack-cache miss and
// shares the read port with the dribbler.
//
// Ports:
//   clk, reset_l        core clock, asynchronous active-low reset
//   dec_*               decoded RS2 request (valid, one-hot offset select,
//                       index byte, lvars flag, long flag)
//   vars_ptr            current VARS word address
//   hold                pipeline hold
//   sc_miss             miss for the read issued in the previous cycle
//   sc_fill_done        miss fill complete (one-cycle pulse)
//   drib_req/drib_addr  dribbler port request and read address
//   dec_ack, drib_gnt   combinational accept / grant for this cycle
//   sc_rd_en/addr/hi    registered read strobe, address, second-word flag
//   rs2_busy            a long second word or a miss replay is pending
//
// Optional feature (macro RS2_STARVE_GUARD_EN): after DRIB_STARVE
// consecutive denied dribbler cycles the dribbler is forced a slot over the
// decoder. Without the macro the decoder always has priority.
module rs2_lv_sched #(
  parameter int ADDR_W = 6
`ifdef RS2_STARVE_GUARD_EN
  , parameter int DRIB_STARVE = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              dec_valid,
  input  logic [4:0]        dec_offset_sel,
  input  logic [7:0]        dec_nxt_byte,
  input  logic              dec_lvars_acc,
  input  logic              dec_long,
  input  logic [ADDR_W-1:0] vars_ptr,
  input  logic              hold,
  input  logic              sc_miss,
  input  logic              sc_fill_done,
  input  logic              drib_req,
  input  logic [ADDR_W-1:0] drib_addr,
  output logic              dec_ack,
  output logic              drib_gnt,
  output logic              sc_rd_en,
  output logic [ADDR_W-1:0] sc_rd_addr,
  output logic              sc_rd_hi,
  output logic              rs2_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_MISS = 2'd2
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   hi_addr_r;
  logic [ADDR_W-1:0]   miss_addr_r;
  logic                miss_hi_r;
  logic                miss_long_r;
  logic                rd_en_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                rd_hi_r;

  logic [7:0]          offset_s;
  logic [ADDR_W+7:0]   sum_s;
  logic [ADDR_W-1:0]   req_addr_s;
  logic                miss_s;
  logic                open_s;
  logic                force_drib_s;
  logic                ack_s;
  logic                gnt_s;

  // Offset select: highest set bit wins, all-zero selects offset 0.
  always_comb begin
    offset_s = 8'd0;
    if (dec_offset_sel[4]) begin
      offset_s = dec_nxt_byte;
    end else if (dec_offset_sel[3]) begin
      offset_s = 8'd3;
    end else if (dec_offset_sel[2]) begin
      offset_s = 8'd2;
    end else if (dec_offset_sel[1]) begin
      offset_s = 8'd1;
    end else begin
      offset_s = 8'd0;
    end
  end

  // Sum is formed wide and truncated so the address wraps modulo 2^ADDR_W.
  assign sum_s      = {8'd0, vars_ptr} + {{ADDR_W{1'b0}}, offset_s};
  assign req_addr_s = sum_s[ADDR_W-1:0];

  // A miss only applies to a read actually issued last cycle.
  assign miss_s = sc_miss & rd_en_r;

`ifdef RS2_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(DRIB_STARVE + 1);
  logic [CNT_W-1:0] starve_cnt_r;

  assign force_drib_s = (starve_cnt_r == CNT_W'(DRIB_STARVE)) & drib_req;

  // Count consecutive IDLE cycles in which the dribbler is denied.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      if (gnt_s || !drib_req) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if (starve_cnt_r != CNT_W'(DRIB_STARVE)) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  assign force_drib_s = 1'b0;
`endif

  // Port arbitration: only an IDLE, unheld cycle without a pending miss
  // offers a slot, so a miss never drops a freshly accepted request.
  always_comb begin
    ack_s  = 1'b0;
    gnt_s  = 1'b0;
    open_s = (state_r == ST_IDLE) && !hold && !miss_s;
    if (open_s) begin
      if (dec_valid && !force_drib_s) begin
        ack_s = 1'b1;
        gnt_s = 1'b0;
      end else if (drib_req) begin
        ack_s = 1'b0;
        gnt_s = 1'b1;
      end else begin
        ack_s = 1'b0;
        gnt_s = 1'b0;
      end
    end else begin
      ack_s = 1'b0;
      gnt_s = 1'b0;
    end
  end

  // Scheduler FSM with registered read-port outputs.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_r     <= ST_IDLE;
      hi_addr_r   <= {ADDR_W{1'b0}};
      miss_addr_r <= {ADDR_W{1'b0}};
      miss_hi_r   <= 1'b0;
      miss_long_r <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {ADDR_W{1'b0}};
      rd_hi_r     <= 1'b0;
    end else begin
      rd_en_r <= 1'b0;
      rd_hi_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (miss_s) begin
            // Missed read was a short, a dribbler read or a second word.
            miss_addr_r <= rd_addr_r;
            miss_hi_r   <= rd_hi_r;
            miss_long_r <= 1'b0;
            state_r     <= ST_MISS;
          end else if (ack_s && dec_lvars_acc) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= req_addr_s;
            if (dec_long) begin
              hi_addr_r <= req_addr_s + ADDR_W'(1);
              state_r   <= ST_HI;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (gnt_s) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= drib_addr;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HI: begin
          if (miss_s) begin
            // First word of a long missed; the second word stays pending.
            miss_addr_r <= rd_addr_r;
            miss_hi_r   <= rd_hi_r;
            miss_long_r <= 1'b1;
            state_r     <= ST_MISS;
          end else if (!hold) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= hi_addr_r;
            rd_hi_r   <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_HI;
          end
        end
        ST_MISS: begin
          // Replay ignores hold so the fill result is consumed at once.
          if (sc_fill_done) begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= miss_addr_r;
            rd_hi_r   <= miss_hi_r;
            state_r   <= miss_long_r ? ST_HI : ST_IDLE;
          end else begin
            state_r <= ST_MISS;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign dec_ack    = ack_s;
  assign drib_gnt   = gnt_s;
  assign sc_rd_en   = rd_en_r;
  assign sc_rd_addr = rd_addr_r;
  assign sc_rd_hi   = rd_hi_r;
  assign rs2_busy   = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rs2_lv_sched.sv
// Bench for rs2_lv_sched: directed vectors with hand-computed literal
// expectations, plus a queue-based model compared on every falling edge.
module tb_rs2_lv_sched;
  localparam int AW = 6;
  localparam int DS = 4;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          dec_valid = 1'b0;
  logic [4:0]    dec_offset_sel = 5'd0;
  logic [7:0]    dec_nxt_byte = 8'd0;
  logic          dec_lvars_acc = 1'b0;
  logic          dec_long = 1'b0;
  logic [AW-1:0] vars_ptr = '0;
  logic          hold = 1'b0;
  logic          sc_miss = 1'b0;
  logic          sc_fill_done = 1'b0;
  logic          drib_req = 1'b0;
  logic [AW-1:0] drib_addr = '0;
  logic          dec_ack, drib_gnt, sc_rd_en, sc_rd_hi, rs2_busy;
  logic [AW-1:0] sc_rd_addr;

  rs2_lv_sched #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_l(reset_l), .dec_valid(dec_valid),
    .dec_offset_sel(dec_offset_sel), .dec_nxt_byte(dec_nxt_byte),
    .dec_lvars_acc(dec_lvars_acc), .dec_long(dec_long), .vars_ptr(vars_ptr),
    .hold(hold), .sc_miss(sc_miss), .sc_fill_done(sc_fill_done),
    .drib_req(drib_req), .drib_addr(drib_addr), .dec_ack(dec_ack),
    .drib_gnt(drib_gnt), .sc_rd_en(sc_rd_en), .sc_rd_addr(sc_rd_addr),
    .sc_rd_hi(sc_rd_hi), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic          hi;
  } word_t;

  word_t         pend[$];   // words still owed to the port (second word of a long)
  bit            waiting;   // a read missed and awaits its fill
  word_t         replay;
  bit            m_en;
  logic [AW-1:0] m_addr;
  bit            m_hi;
  int            starve;

  function automatic logic [AW-1:0] m_req_addr();
    int off;
    if (dec_offset_sel[4])      off = int'(dec_nxt_byte);
    else if (dec_offset_sel[3]) off = 3;
    else if (dec_offset_sel[2]) off = 2;
    else if (dec_offset_sel[1]) off = 1;
    else                        off = 0;
    return AW'((int'(vars_ptr) + off) % (1 << AW));
  endfunction

  function automatic bit m_open();
    return (pend.size() == 0) && !waiting && !hold && !(sc_miss && m_en);
  endfunction

  function automatic bit m_force();
`ifdef RS2_STARVE_GUARD_EN
    return (starve >= DS) && drib_req;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ack();
    return m_open() && dec_valid && !m_force();
  endfunction

  function automatic bit m_gnt();
    return m_open() && drib_req && !m_ack();
  endfunction

  task automatic model_reset();
    pend.delete();
    waiting = 1'b0;
    m_en = 1'b0;
    m_addr = '0;
    m_hi = 1'b0;
    starve = 0;
  endtask

  // Predict the registered outputs after the coming rising edge.
  task automatic model_step();
    bit a, g, miss, n_en, n_hi;
    logic [AW-1:0] n_addr;
    word_t w;
    a = m_ack();
    g = m_gnt();
    miss = sc_miss && m_en;
    if (pend.size() == 0 && !waiting) begin
      if (drib_req && !g) starve = (starve < DS) ? starve + 1 : DS;
      else starve = 0;
    end
    n_en = 1'b0; n_addr = m_addr; n_hi = 1'b0;
    if (waiting) begin
      if (sc_fill_done) begin
        n_en = 1'b1; n_addr = replay.a; n_hi = replay.hi; waiting = 1'b0;
      end
    end else if (miss) begin
      waiting = 1'b1;
      replay.a = m_addr;
      replay.hi = m_hi;
    end else if (pend.size() != 0) begin
      if (!hold) begin
        w = pend.pop_front();
        n_en = 1'b1; n_addr = w.a; n_hi = w.hi;
      end
    end else if (a && dec_lvars_acc) begin
      n_en = 1'b1; n_addr = m_req_addr();
      if (dec_long) begin
        w.a = n_addr + AW'(1);
        w.hi = 1'b1;
        pend.push_back(w);
      end
    end else if (g) begin
      n_en = 1'b1; n_addr = drib_addr;
    end
    m_en = n_en; m_addr = n_addr; m_hi = n_hi;
  endtask

  // Compare process: check every falling edge, then advance the model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset_l) model_reset();
      chk1("m_ack", dec_ack, m_ack());
      chk1("m_gnt", drib_gnt, m_gnt());
      chk1("m_rd_en", sc_rd_en, m_en);
      if (m_en) begin
        chka("m_rd_addr", sc_rd_addr, m_addr);
        chk1("m_rd_hi", sc_rd_hi, m_hi);
      end
      chk1("m_busy", rs2_busy, (pend.size() != 0) || waiting);
      if (reset_l) model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic en, input logic [AW-1:0] a, input logic hi);
    chk1({name, "_en"}, sc_rd_en, en);
    if (en) begin
      chka({name, "_addr"}, sc_rd_addr, a);
      chk1({name, "_hi"}, sc_rd_hi, hi);
    end
  endtask

  logic [AW-1:0] ov_vars[4]  = '{6'd0, 6'd5, 6'd7, 6'd60};
  logic [4:0]    ov_sel[4]   = '{5'b01011, 5'b10000, 5'b00000, 5'b11000};
  logic [7:0]    ov_byte[4]  = '{8'd0, 8'hFF, 8'd0, 8'h09};
  logic [AW-1:0] ov_exp[4]   = '{6'd3, 6'd4, 6'd7, 6'd5};

  initial begin
    logic exp_g;
    #12;
    rd("rst", 1'b0, '0, 1'b0);
    chka("rst_addr", sc_rd_addr, 6'd0);
    chk1("rst_hi", sc_rd_hi, 1'b0);
    chk1("rst_busy", rs2_busy, 1'b0);
    tick();
    reset_l = 1'b1;
    tick();

    // Short read with offset 2 from VARS=10.
    vars_ptr = 6'd10; dec_offset_sel = 5'b00100; dec_lvars_acc = 1'b1;
    dec_long = 1'b0; dec_valid = 1'b1;
    #1 chk1("t1_ack", dec_ack, 1'b1);
    tick(); dec_valid = 1'b0;
    rd("t1", 1'b1, 6'd12, 1'b0);
    chk1("t1_busy", rs2_busy, 1'b0);
    tick(); rd("t1_idle", 1'b0, '0, 1'b0);

    // Offset priority and wrap cases.
    for (int i = 0; i < 4; i++) begin
      vars_ptr = ov_vars[i]; dec_offset_sel = ov_sel[i]; dec_nxt_byte = ov_byte[i];
      dec_valid = 1'b1;
      #1 chk1("off_ack", dec_ack, 1'b1);
      tick(); dec_valid = 1'b0;
      rd("off", 1'b1, ov_exp[i], 1'b0);
      tick();
    end

    // Long read wrapping past the top of the address space.
    vars_ptr = 6'd62; dec_offset_sel = 5'b10000; dec_nxt_byte = 8'd1;
    dec_long = 1'b1; dec_valid = 1'b1;
    tick(); dec_valid = 1'b0;
    rd("wrap_lo", 1'b1, 6'd63, 1'b0);
    chk1("wrap_busy1", rs2_busy, 1'b1);
    tick();
    rd("wrap_hi", 1'b1, 6'd0, 1'b1);
    chk1("wrap_busy0", rs2_busy, 1'b0);
    tick(); rd("wrap_idle", 1'b0, '0, 1'b0);

    // Hold for two cycles while the second word is pending.
    vars_ptr = 6'd5; dec_offset_sel = 5'b00001; dec_valid = 1'b1;
    tick(); dec_valid = 1'b0; hold = 1'b1;
    rd("hold_lo", 1'b1, 6'd5, 1'b0);
    tick(); rd("hold_c1", 1'b0, '0, 1'b0);
    tick(); rd("hold_c2", 1'b0, '0, 1'b0); hold = 1'b0;
    tick(); rd("hold_hi", 1'b1, 6'd6, 1'b1);
    tick();

    // Miss on the first word of a long, then replay.
    vars_ptr = 6'd20; dec_valid = 1'b1;
    tick(); dec_valid = 1'b0;
    rd("miss_lo", 1'b1, 6'd20, 1'b0); sc_miss = 1'b1;
    tick(); sc_miss = 1'b0;
    rd("miss_wait", 1'b0, '0, 1'b0);
    chk1("miss_busy", rs2_busy, 1'b1);
    tick(); rd("miss_wait2", 1'b0, '0, 1'b0); sc_fill_done = 1'b1;
    tick(); sc_fill_done = 1'b0;
    rd("miss_replay", 1'b1, 6'd20, 1'b0);
    tick(); rd("miss_hi", 1'b1, 6'd21, 1'b1);
    tick();

    // Dribbler read that misses and is replayed.
    dec_long = 1'b0; drib_req = 1'b1; drib_addr = 6'd33;
    #1 chk1("drib_gnt", drib_gnt, 1'b1);
    tick(); drib_req = 1'b0;
    rd("drib_rd", 1'b1, 6'd33, 1'b0); sc_miss = 1'b1;
    tick(); sc_miss = 1'b0; sc_fill_done = 1'b1;
    chk1("drib_busy", rs2_busy, 1'b1);
    tick(); sc_fill_done = 1'b0;
    rd("drib_replay", 1'b1, 6'd33, 1'b0);
    chk1("drib_busy0", rs2_busy, 1'b0);
    tick();

    // Arbitration with both requesters present.
    drib_req = 1'b1; drib_addr = 6'd40; dec_valid = 1'b1; dec_lvars_acc = 1'b0;
    for (int i = 1; i <= 6; i++) begin
`ifdef RS2_STARVE_GUARD_EN
      exp_g = (i == 5);
`else
      exp_g = 1'b0;
`endif
      #1;
      chk1("arb_ack", dec_ack, !exp_g);
      chk1("arb_gnt", drib_gnt, exp_g);
      tick();
    end
    hold = 1'b1;
    #1 chk1("hold_ack", dec_ack, 1'b0);
    chk1("hold_gnt", drib_gnt, 1'b0);
    tick();
    hold = 1'b0; drib_req = 1'b0; dec_valid = 1'b0;
    tick();

    // Asynchronous reset while waiting for a fill.
    vars_ptr = 6'd0; dec_offset_sel = 5'b01000; dec_lvars_acc = 1'b1; dec_valid = 1'b1;
    tick(); dec_valid = 1'b0;
    rd("ar_rd", 1'b1, 6'd3, 1'b0); sc_miss = 1'b1;
    tick(); sc_miss = 1'b0;
    chk1("ar_miss_busy", rs2_busy, 1'b1);
    #1 reset_l = 1'b0;
    #1;
    rd("ar_rst", 1'b0, '0, 1'b0);
    chka("ar_addr", sc_rd_addr, 6'd0);
    chk1("ar_hi", sc_rd_hi, 1'b0);
    chk1("ar_busy", rs2_busy, 1'b0);
    chk1("ar_ack", dec_ack, 1'b0);
    chk1("ar_gnt", drib_gnt, 1'b0);
    tick(); reset_l = 1'b1;
    vars_ptr = 6'd8; dec_offset_sel = 5'b00010; dec_valid = 1'b1;
    #1 chk1("ar_post_ack", dec_ack, 1'b1);
    tick(); dec_valid = 1'b0;
    rd("ar_post", 1'b1, 6'd9, 1'b0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs2_lv_sched.md
Name: rs2_lv_sched

Overview:
Scheduler for the stack-cache RS2 read port. It takes a decoded RS2 request (offset select, next byte, lvars flag, long flag) and forms the read address relative to VARS. It sequences 64-bit (lload/dload) reads over two cycles, replays the read after a stack-cache miss, and shares the port with the dribbler. It sits between the RS2 decoder and the stack-cache read port in the IFU/IU boundary.

Parameters:
ADDR_W, 6, stack-cache word address width; all address arithmetic is modulo 2^ADDR_W
DRIB_STARVE, 4, consecutive denied dribbler cycles before a forced dribbler slot (optional feature only)

Ports:
clk  in  1  core clock
reset_l  in  1  asynchronous active-low reset
dec_valid  in  1  decoded RS2 request present
dec_offset_sel  in  5  one-hot offset select: [0]=0, [1]=1, [2]=2, [3]=3, [4]=dec_nxt_byte
dec_nxt_byte  in  8  index byte for offset_sel[4]
dec_lvars_acc  in  1  request reads local variables (else no cache read)
dec_long  in  1  64-bit access, two words
vars_ptr  in  ADDR_W  current VARS word address
hold  in  1  pipeline hold
sc_miss  in  1  miss for the read issued in the previous cycle
sc_fill_done  in  1  miss fill complete (one-cycle pulse)
drib_req  in  1  dribbler wants the port
drib_addr  in  ADDR_W  dribbler read address
dec_ack  out  1  request consumed this cycle (combinational)
drib_gnt  out  1  dribbler owns the port this cycle (combinational)
sc_rd_en  out  1  registered read strobe
sc_rd_addr  out  ADDR_W  registered read address
sc_rd_hi  out  1  registered flag: second word of a long
rs2_busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_l=0): state=IDLE; sc_rd_en=0; sc_rd_addr=0; sc_rd_hi=0; rs2_busy=0; internal counters=0. Deasserting reset mid-sequence drops any pending long or miss replay.
- Offset: the highest set bit of dec_offset_sel wins. All-zero selects 0. The [4] case zero-extends dec_nxt_byte. addr = vars_ptr + offset, truncated to ADDR_W, with wrap-around.
- FSM states: IDLE, HI (second word pending), MISS (waiting for fill).
- IDLE, hold=0:
  - drib_req with no dec_valid: drib_gnt=1 and the dribbler read issues.
  - dec_valid with no drib_req: dec_ack=1.
  - Both present: the decoder wins.
- IDLE, hold=1: dec_ack=0, drib_gnt=0.
- dec_ack with dec_lvars_acc=0: no read; sc_rd_en=0 next cycle; state stays IDLE.
- dec_ack with dec_lvars_acc=1: next cycle sc_rd_en=1, sc_rd_addr=addr, sc_rd_hi=0. If dec_long=1, addr+1 is latched and state moves to HI.
- HI, hold=0: next cycle sc_rd_en=1, sc_rd_addr=latched addr+1 (wraps), sc_rd_hi=1; state returns to IDLE. No ack or grant is given in HI.
- HI, hold=1: sc_rd_en=0 next cycle; state and latched address are retained.
- Latency: accept in cycle N, read strobe in N+1. A long issues its second word in N+2 when there is no hold.
- sc_miss=1 in the cycle after any sc_rd_en=1 (dribbler reads included):
  - The missed read's addr/hi are captured and state goes to MISS.
  - Any HI issue in that same cycle is suppressed and the pending second word is kept.
  - In MISS: sc_rd_en=0, no ack, no grant.
- sc_fill_done in MISS: the captured read re-issues next cycle (sc_rd_en=1). State then goes to HI if the missed read was a long's first word, else IDLE. This transition ignores hold.
- sc_miss and sc_fill_done are ignored in all other cases.
- rs2_busy=1 in HI and MISS.

Optional Feature:
- RS2_STARVE_GUARD_EN defined: a counter increments each IDLE cycle in which drib_req=1 and drib_gnt=0, and clears on grant or when drib_req=0. When the count reaches DRIB_STARVE, the dribbler wins the next IDLE/no-hold cycle over dec_valid (dec_ack=0), and the counter clears.
- Undefined: strict decoder priority, no counter. The dribbler can starve indefinitely.

Test Plan:
- Reset: vars_ptr=10; offset_sel=5'b00100, lvars=1, long=0, valid for one cycle -> dec_ack=1; next cycle sc_rd_en=1, addr=12, hi=0; then IDLE.
- Long wrap: vars_ptr=62; offset_sel[4], nxt_byte=1, long=1 -> reads addr 63 (hi=0) then 0 (hi=1) in consecutive cycles; rs2_busy=1 for one cycle.
- Hold in HI: after first word of long at addr 5, hold=1 for 2 cycles -> sc_rd_en=0 both cycles; addr 6 (hi=1) issues the cycle after hold drops.
- Miss replay: sc_miss=1 after first word at addr 20 of a long -> MISS, sc_rd_en=0; sc_fill_done pulse -> addr 20 re-issued, then addr 21 hi=1.
- Arbitration: drib_req=1 and dec_valid=1 (lvars=0) continuously -> dec_ack every cycle, no sc_rd_en. With RS2_STARVE_GUARD_EN and DRIB_STARVE=4, drib_gnt=1 on the 5th cycle, dec_ack=0 that cycle.
- Async reset mid-MISS: reset_l low in MISS -> all outputs 0 immediately. After release, dec_valid is accepted on the first cycle.
